// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
//   Shared definitions for the NoC router datapath.
//   - Default flit width, buffer depth and em_pl counter width.
//   - Flit-type codes carried in the two MSBs of every flit.
//   - State type for the output-port lock/grant FSM.
//   - flit_type(): extracts the type field from a default-width flit.
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int FLIT_W    = 64;
    localparam int BUF_DEPTH = 4;
    localparam int CNT_W     = 3;

    // Flit type field, bits [FLIT_W-1:FLIT_W-2]
    localparam logic [1:0] FLIT_BODY      = 2'b00;
    localparam logic [1:0] FLIT_HEAD      = 2'b01;
    localparam logic [1:0] FLIT_TAIL      = 2'b10;
    localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } tx_state_e;

    function automatic logic [1:0] flit_type(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: 2];
    endfunction

    // True for the two types that may open a packet.
    function automatic logic starts_packet(input logic [1:0] ftype);
        return (ftype == FLIT_HEAD) || (ftype == FLIT_HEAD_TAIL);
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
//   Purely combinational round-robin arbiter. The winner is the first
//   requester found at or after ptr, wrapping from N-1 back to 0.
// Ports
//   req        in   N       request vector
//   ptr        in   IDX_W   index with highest priority this cycle
//   grant      out  N       one-hot grant (all zero when no request)
//   grant_idx  out  IDX_W   index of the granted requester (0 when none)
//   any        out  1       at least one request present
// -----------------------------------------------------------------------------
module noc_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_port_tx.sv
// -----------------------------------------------------------------------------
// noc_output_port_tx
//   Output-port transmitter of a NoC router. Reads the head flit of one of
//   N_IN input buffers (chosen round-robin), pops it, and pushes it one cycle
//   later into the downstream router's buffer. Wormhole switching: a grant is
//   held from a HEAD flit to its TAIL flit. Flits are only sent while the
//   downstream buffer has a free place after accounting for the push that is
//   still on the wire.
// Ports
//   clk        in   1             clock, all state on posedge
//   reset      in   1             synchronous, active-high
//   in_flit    in   N_IN*FLIT_W   head flit of each input buffer (slice i = input i)
//   in_em_pl   in   N_IN*CNT_W    empty places of each input buffer (< DEPTH = non-empty)
//   in_req     in   N_IN          head flit of input i is routed to this port
//   in_pop     out  N_IN          combinational pop, at most one bit high
//   ds_em_pl   in   CNT_W         empty places of the downstream buffer
//   ds_push    out  1             registered push into downstream buffer
//   ds_flit    out  FLIT_W        registered flit into downstream buffer
//   locked     out  1             packet in progress, grant held
//   grant_idx  out  IDX_W         input currently / last granted
//   proto_err  out  1             sticky: BODY/TAIL offered while unlocked
// -----------------------------------------------------------------------------
module noc_output_port_tx #(
    parameter  int N_IN   = 4,
    parameter  int FLIT_W = noc_pkg::FLIT_W,
    parameter  int DEPTH  = noc_pkg::BUF_DEPTH,
    parameter  int CNT_W  = noc_pkg::CNT_W,
    localparam int IDX_W  = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN*FLIT_W-1:0]  in_flit,
    input  logic [N_IN*CNT_W-1:0]   in_em_pl,
    input  logic [N_IN-1:0]         in_req,
    output logic [N_IN-1:0]         in_pop,
    input  logic [CNT_W-1:0]        ds_em_pl,
    output logic                    ds_push,
    output logic [FLIT_W-1:0]       ds_flit,
    output logic                    locked,
    output logic [IDX_W-1:0]        grant_idx,
    output logic                    proto_err
);

    import noc_pkg::*;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(N_IN - 1);

    tx_state_e               state;
    logic [IDX_W-1:0]        rr_ptr;

    logic [N_IN-1:0][1:0]    ftype;
    logic [N_IN-1:0]         nonempty;
    logic [N_IN-1:0]         head_type;
    logic [N_IN-1:0]         eligible;
    logic [N_IN-1:0]         bad_offer;

    logic [N_IN-1:0]         arb_oh;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    logic [CNT_W-1:0]        em_clamped;
    logic signed [CNT_W:0]   free;
    logic                    credit_ok;

    logic                    send;
    logic [IDX_W-1:0]        sel_idx;
    logic [N_IN-1:0]         sel_oh;
    logic [FLIT_W-1:0]       sel_flit;
    logic [1:0]              sel_type;
    logic                    err_cond;

    // Per-input decode of the offered head flit
    always_comb begin
        ftype     = '0;
        nonempty  = '0;
        head_type = '0;
        for (int i = 0; i < N_IN; i++) begin
            ftype[i]     = in_flit[i*FLIT_W + FLIT_W-2 +: 2];
            nonempty[i]  = in_em_pl[i*CNT_W +: CNT_W] < DEPTH_C;
            head_type[i] = starts_packet(ftype[i]);
        end
    end

    assign eligible  = in_req & nonempty & head_type;
    assign bad_offer = in_req & nonempty & ~head_type;

    noc_rr_arbiter #(
        .N (N_IN)
    ) u_arb (
        .req       (eligible),
        .ptr       (rr_ptr),
        .grant     (arb_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    // Credit check: ds_em_pl has not yet seen the push currently on the wire,
    // so subtract it. Done in one extra signed bit so 0 - 1 reads as negative.
    assign em_clamped = (ds_em_pl > DEPTH_C) ? DEPTH_C : ds_em_pl;
    assign free       = $signed({1'b0, em_clamped}) - $signed({{CNT_W{1'b0}}, ds_push});
    assign credit_ok  = ~free[CNT_W] & (free != '0);

    // Source selection: the held grant while locked, the arbiter otherwise.
    // in_req is deliberately ignored while locked.
    always_comb begin
        sel_idx = arb_idx;
        sel_oh  = arb_oh;
        send    = arb_any & credit_ok;
        if (state == ST_LOCKED) begin
            sel_idx            = grant_idx;
            sel_oh             = '0;
            sel_oh[grant_idx]  = 1'b1;
            send               = nonempty[grant_idx] & credit_ok;
        end
        if (reset) begin
            send = 1'b0;
        end
    end

    assign in_pop = send ? sel_oh : '0;

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_flit = in_flit[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign sel_type = sel_flit[FLIT_W-1 -: 2];

    // A BODY/TAIL at the head of a requesting input with no packet open is a
    // protocol violation; the flit is left in place (not eligible).
    assign err_cond = (state == ST_IDLE) && (|bad_offer);

    assign locked = (state == ST_LOCKED);

    // Lock/grant FSM, output register and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant_idx <= '0;
            rr_ptr    <= '0;
            ds_push   <= 1'b0;
            ds_flit   <= '0;
            proto_err <= 1'b0;
        end else begin
            ds_push <= send;
            if (send) begin
                ds_flit <= sel_flit;
            end
            if (err_cond) begin
                proto_err <= 1'b1;
            end
            if (state == ST_IDLE) begin
                if (send) begin
                    grant_idx <= arb_idx;
                    rr_ptr    <= (arb_idx == LAST_C) ? '0 : arb_idx + IDX_W'(1);
                    if (sel_type == FLIT_HEAD) begin
                        state <= ST_LOCKED;
                    end
                end
            end else begin
                // Only a TAIL closes the packet; re-arbitration waits a cycle.
                if (send && (sel_type == FLIT_TAIL)) begin
                    state <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_noc_output_port_tx.sv
module tb_noc_output_port_tx;

    localparam logic [1:0] B  = 2'b00;
    localparam logic [1:0] H  = 2'b01;
    localparam logic [1:0] T  = 2'b10;
    localparam logic [1:0] HT = 2'b11;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_req;
    logic [2:0]   em [4];
    logic [63:0]  fl [4];
    logic [2:0]   ds_em_pl;
    logic [255:0] in_flit;
    logic [11:0]  in_em_pl;
    logic [3:0]   in_pop;
    logic         ds_push;
    logic [63:0]  ds_flit;
    logic         locked;
    logic [1:0]   grant_idx;
    logic         proto_err;

    assign in_flit  = {fl[3], fl[2], fl[1], fl[0]};
    assign in_em_pl = {em[3], em[2], em[1], em[0]};

    always #5 clk = ~clk;

    noc_output_port_tx dut (
        .clk       (clk),
        .reset     (reset),
        .in_flit   (in_flit),
        .in_em_pl  (in_em_pl),
        .in_req    (in_req),
        .in_pop    (in_pop),
        .ds_em_pl  (ds_em_pl),
        .ds_push   (ds_push),
        .ds_flit   (ds_flit),
        .locked    (locked),
        .grant_idx (grant_idx),
        .proto_err (proto_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int tag,
                       input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0d: got %h expected %h", name, tag, act, exp);
        end
    endtask

    // Directed vector: inputs for one cycle and the expected outputs
    // (in_pop during the cycle, registers after the edge).
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] ne;
        logic [7:0] ty;
        logic [2:0] ds;
        logic [3:0] pop;
        logic       push;
        logic       lck;
        logic [1:0] gi;
        logic       err;
    } vec_t;

    vec_t        tab[$];
    logic [63:0] exp_flit = '0;

    function automatic logic [7:0] ty4(input logic [1:0] t3, t2, t1, t0);
        return {t3, t2, t1, t0};
    endfunction

    task automatic add(input logic r, input logic [3:0] req, ne, input logic [7:0] ty,
                       input logic [2:0] ds, input logic [3:0] pop,
                       input logic push, lck, input logic [1:0] gi, input logic err);
        vec_t v;
        v.rst = r; v.req = req; v.ne = ne; v.ty = ty; v.ds = ds;
        v.pop = pop; v.push = push; v.lck = lck; v.gi = gi; v.err = err;
        tab.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int tag);
        reset    = v.rst;
        in_req   = v.req;
        ds_em_pl = v.ds;
        for (int i = 0; i < 4; i++) begin
            em[i] = v.ne[i] ? 3'd2 : 3'd4;
            fl[i] = {v.ty[2*i +: 2], 62'(tag * 16 + i)};
        end
        #3;
        chk("in_pop", tag, 64'(in_pop), 64'(v.pop));
        if (v.rst) exp_flit = '0;
        else for (int i = 0; i < 4; i++) if (v.pop[i]) exp_flit = fl[i];
        @(posedge clk);
        #1;
        chk("ds_push",   tag, 64'(ds_push),   64'(v.push));
        chk("ds_flit",   tag, ds_flit,        exp_flit);
        chk("locked",    tag, 64'(locked),    64'(v.lck));
        chk("grant_idx", tag, 64'(grant_idx), 64'(v.gi));
        chk("proto_err", tag, 64'(proto_err), 64'(v.err));
    endtask

    // Reference model state for the random phase
    bit          m_locked;
    int          m_g, m_rr;
    bit          m_push, m_err;
    logic [63:0] m_flit;

    task automatic rand_cycle(input int c);
        logic [1:0] ty [4];
        logic [3:0] ep;
        int         free, win, dsv;
        bit         err_set;
        reset    = (c == 0) || ($urandom_range(0, 39) == 0);
        in_req   = 4'($urandom);
        ds_em_pl = 3'($urandom_range(0, 7));
        for (int i = 0; i < 4; i++) begin
            em[i] = 3'($urandom_range(0, 4));
            ty[i] = 2'($urandom_range(0, 3));
            fl[i] = {ty[i], 30'($urandom), 32'(c * 4 + i)};
        end
        dsv     = (int'(ds_em_pl) > 4) ? 4 : int'(ds_em_pl);
        free    = dsv - int'(m_push);
        win     = -1;
        err_set = 1'b0;
        if (!reset) begin
            if (m_locked) begin
                if (em[m_g] < 4 && free > 0) win = m_g;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int j;
                    j = (m_rr + k) % 4;
                    if (win < 0 && in_req[j] && em[j] < 4 && (ty[j] == H || ty[j] == HT))
                        win = j;
                end
                if (free <= 0) win = -1;
                for (int i = 0; i < 4; i++)
                    if (in_req[i] && em[i] < 4 && (ty[i] == B || ty[i] == T)) err_set = 1'b1;
            end
        end
        ep = '0;
        if (win >= 0) ep[win] = 1'b1;
        #3;
        chk("rnd_in_pop", c, 64'(in_pop), 64'(ep));
        @(posedge clk);
        #1;
        if (reset) begin
            m_locked = 0; m_g = 0; m_rr = 0; m_push = 0; m_err = 0; m_flit = '0;
        end else begin
            if (err_set) m_err = 1;
            m_push = (win >= 0);
            if (win >= 0) begin
                m_flit = fl[win];
                if (!m_locked) begin
                    m_g      = win;
                    m_rr     = (win + 1) % 4;
                    m_locked = (ty[win] == H);
                end else if (ty[win] == T) begin
                    m_locked = 0;
                end
            end
        end
        chk("rnd_ds_push",   c, 64'(ds_push),   64'(m_push));
        chk("rnd_ds_flit",   c, ds_flit,        m_flit);
        chk("rnd_locked",    c, 64'(locked),    64'(m_locked));
        chk("rnd_grant_idx", c, 64'(grant_idx), 64'(m_g));
        chk("rnd_proto_err", c, 64'(proto_err), 64'(m_err));
    endtask

    initial begin
        reset    = 1'b1;
        in_req   = '0;
        ds_em_pl = 3'd4;
        for (int i = 0; i < 4; i++) begin
            em[i] = 3'd4;
            fl[i] = '0;
        end

        // reset state
        add(1, 4'b0000, 4'b0000, ty4(B, B, B, B), 4, 4'b0000, 0, 0, 0, 0);
        // single HEAD_TAIL on input 2
        add(0, 4'b0100, 4'b0100, ty4(B, HT, B, B), 4, 4'b0100, 1, 0, 2, 0);
        add(0, 4'b0000, 4'b0000, ty4(B, B, B, B),  4, 4'b0000, 0, 0, 2, 0);
        // 4-flit packet on input 0 while input 1 waits with a HEAD
        add(0, 4'b0011, 4'b0011, ty4(B, B, H, H), 4, 4'b0001, 1, 1, 0, 0);
        add(0, 4'b0010, 4'b0011, ty4(B, B, H, B), 4, 4'b0001, 1, 1, 0, 0);
        add(0, 4'b0010, 4'b0011, ty4(B, B, H, B), 4, 4'b0001, 1, 1, 0, 0);
        add(0, 4'b0010, 4'b0011, ty4(B, B, H, T), 4, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b0010, 4'b0010, ty4(B, B, H, B), 4, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, T, B), 4, 4'b0010, 1, 0, 1, 0);
        // BODY / TAIL offered while unlocked: no pop, sticky error
        add(0, 4'b1000, 4'b1000, ty4(B, B, B, B), 4, 4'b0000, 0, 0, 1, 1);
        add(0, 4'b1000, 4'b1000, ty4(T, B, B, B), 4, 4'b0000, 0, 0, 1, 1);
        add(1, 4'b1000, 4'b1000, ty4(B, B, B, B), 4, 4'b0000, 0, 0, 0, 0);
        // all inputs HEAD_TAIL: grants rotate 0,1,2,3,0
        add(0, 4'b1111, 4'b1111, ty4(HT, HT, HT, HT), 4, 4'b0001, 1, 0, 0, 0);
        add(0, 4'b1111, 4'b1111, ty4(HT, HT, HT, HT), 4, 4'b0010, 1, 0, 1, 0);
        add(0, 4'b1111, 4'b1111, ty4(HT, HT, HT, HT), 4, 4'b0100, 1, 0, 2, 0);
        add(0, 4'b1111, 4'b1111, ty4(HT, HT, HT, HT), 4, 4'b1000, 1, 0, 3, 0);
        add(0, 4'b1111, 4'b1111, ty4(HT, HT, HT, HT), 4, 4'b0001, 1, 0, 0, 0);
        // reset mid-packet, then a fresh packet
        add(0, 4'b0100, 4'b0100, ty4(B, H, B, B), 4, 4'b0100, 1, 1, 2, 0);
        add(1, 4'b0100, 4'b0100, ty4(B, B, B, B), 4, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0100, 4'b0100, ty4(B, H, B, B), 4, 4'b0100, 1, 1, 2, 0);
        add(0, 4'b0000, 4'b0100, ty4(B, T, B, B), 4, 4'b0100, 1, 0, 2, 0);

        for (int k = 0; k < tab.size(); k++) run_vec(tab[k], k);

        // Credit stall: one free place, stall until the downstream drains
        tab.delete();
        add(1, 4'b0000, 4'b0000, ty4(B, B, B, B), 4, 4'b0000, 0, 0, 0, 0);
        add(0, 4'b0010, 4'b0010, ty4(B, B, H, B), 1, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, B, B), 1, 4'b0000, 0, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, B, B), 0, 4'b0000, 0, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, B, B), 2, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, T, B), 2, 4'b0010, 1, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, ty4(B, B, B, B), 2, 4'b0000, 0, 0, 1, 0);
        // HEAD_TAIL at the head of a locked input is forwarded, lock kept
        add(0, 4'b0010, 4'b0010, ty4(B, B, H, B),  4, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, HT, B), 4, 4'b0010, 1, 1, 1, 0);
        add(0, 4'b0000, 4'b0010, ty4(B, B, T, B),  4, 4'b0010, 1, 0, 1, 0);
        for (int k = 0; k < tab.size(); k++) run_vec(tab[k], 100 + k);

        // Randomized traffic against the reference model
        for (int c = 0; c < 600; c++) rand_cycle(c);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
